// File: rtl/recip_estimate_rom_if.sv
// rtl/recip_estimate_rom_if.sv - lookup bus between the reciprocal seed stage and its estimate table
interface recip_estimate_rom_if;
  logic [7:0] addr_i;
  logic [7:0] data_o;

  modport master (output addr_i, input data_o);
  modport slave (input addr_i, output data_o);
endinterface

// File: rtl/recip_estimate_rom.sv
// rtl/recip_estimate_rom.sv - registered 256x8 reciprocal-estimate significand table
// Entry a holds the fraction bits of round(131072 / (256 + a)), i.e. the normalized 1.xxxxxxxx of 1/m.
module recip_estimate_rom (
  input  logic                 clk,
  input  logic                 reset,
  recip_estimate_rom_if.slave  rom
);

  logic [7:0] rom_q;
  logic [7:0] data_q = 8'h00;

  // Address 0 would need 9 bits (exact 2.0); the seed stage supplies that case, so only the low byte is kept.
  always_comb begin
    rom_q = 8'h00;
    case (rom.addr_i)
      8'h00: rom_q = 8'h00;  8'h01: rom_q = 8'hFE;  8'h02: rom_q = 8'hFC;  8'h03: rom_q = 8'hFA;
      8'h04: rom_q = 8'hF8;  8'h05: rom_q = 8'hF6;  8'h06: rom_q = 8'hF4;  8'h07: rom_q = 8'hF2;
      8'h08: rom_q = 8'hF0;  8'h09: rom_q = 8'hEF;  8'h0A: rom_q = 8'hED;  8'h0B: rom_q = 8'hEB;
      8'h0C: rom_q = 8'hE9;  8'h0D: rom_q = 8'hE7;  8'h0E: rom_q = 8'hE5;  8'h0F: rom_q = 8'hE4;
      8'h10: rom_q = 8'hE2;  8'h11: rom_q = 8'hE0;  8'h12: rom_q = 8'hDE;  8'h13: rom_q = 8'hDD;
      8'h14: rom_q = 8'hDB;  8'h15: rom_q = 8'hD9;  8'h16: rom_q = 8'hD7;  8'h17: rom_q = 8'hD6;
      8'h18: rom_q = 8'hD4;  8'h19: rom_q = 8'hD2;  8'h1A: rom_q = 8'hD1;  8'h1B: rom_q = 8'hCF;
      8'h1C: rom_q = 8'hCE;  8'h1D: rom_q = 8'hCC;  8'h1E: rom_q = 8'hCA;  8'h1F: rom_q = 8'hC9;
      8'h20: rom_q = 8'hC7;  8'h21: rom_q = 8'hC6;  8'h22: rom_q = 8'hC4;  8'h23: rom_q = 8'hC2;
      8'h24: rom_q = 8'hC1;  8'h25: rom_q = 8'hBF;  8'h26: rom_q = 8'hBE;  8'h27: rom_q = 8'hBC;
      8'h28: rom_q = 8'hBB;  8'h29: rom_q = 8'hB9;  8'h2A: rom_q = 8'hB8;  8'h2B: rom_q = 8'hB6;
      8'h2C: rom_q = 8'hB5;  8'h2D: rom_q = 8'hB3;  8'h2E: rom_q = 8'hB2;  8'h2F: rom_q = 8'hB1;
      8'h30: rom_q = 8'hAF;  8'h31: rom_q = 8'hAE;  8'h32: rom_q = 8'hAC;  8'h33: rom_q = 8'hAB;
      8'h34: rom_q = 8'hAA;  8'h35: rom_q = 8'hA8;  8'h36: rom_q = 8'hA7;  8'h37: rom_q = 8'hA5;
      8'h38: rom_q = 8'hA4;  8'h39: rom_q = 8'hA3;  8'h3A: rom_q = 8'hA1;  8'h3B: rom_q = 8'hA0;
      8'h3C: rom_q = 8'h9F;  8'h3D: rom_q = 8'h9D;  8'h3E: rom_q = 8'h9C;  8'h3F: rom_q = 8'h9B;
      8'h40: rom_q = 8'h9A;  8'h41: rom_q = 8'h98;  8'h42: rom_q = 8'h97;  8'h43: rom_q = 8'h96;
      8'h44: rom_q = 8'h95;  8'h45: rom_q = 8'h93;  8'h46: rom_q = 8'h92;  8'h47: rom_q = 8'h91;
      8'h48: rom_q = 8'h90;  8'h49: rom_q = 8'h8E;  8'h4A: rom_q = 8'h8D;  8'h4B: rom_q = 8'h8C;
      8'h4C: rom_q = 8'h8B;  8'h4D: rom_q = 8'h8A;  8'h4E: rom_q = 8'h88;  8'h4F: rom_q = 8'h87;
      8'h50: rom_q = 8'h86;  8'h51: rom_q = 8'h85;  8'h52: rom_q = 8'h84;  8'h53: rom_q = 8'h83;
      8'h54: rom_q = 8'h82;  8'h55: rom_q = 8'h80;  8'h56: rom_q = 8'h7F;  8'h57: rom_q = 8'h7E;
      8'h58: rom_q = 8'h7D;  8'h59: rom_q = 8'h7C;  8'h5A: rom_q = 8'h7B;  8'h5B: rom_q = 8'h7A;
      8'h5C: rom_q = 8'h79;  8'h5D: rom_q = 8'h78;  8'h5E: rom_q = 8'h76;  8'h5F: rom_q = 8'h75;
      8'h60: rom_q = 8'h74;  8'h61: rom_q = 8'h73;  8'h62: rom_q = 8'h72;  8'h63: rom_q = 8'h71;
      8'h64: rom_q = 8'h70;  8'h65: rom_q = 8'h6F;  8'h66: rom_q = 8'h6E;  8'h67: rom_q = 8'h6D;
      8'h68: rom_q = 8'h6C;  8'h69: rom_q = 8'h6B;  8'h6A: rom_q = 8'h6A;  8'h6B: rom_q = 8'h69;
      8'h6C: rom_q = 8'h68;  8'h6D: rom_q = 8'h67;  8'h6E: rom_q = 8'h66;  8'h6F: rom_q = 8'h65;
      8'h70: rom_q = 8'h64;  8'h71: rom_q = 8'h63;  8'h72: rom_q = 8'h62;  8'h73: rom_q = 8'h61;
      8'h74: rom_q = 8'h60;  8'h75: rom_q = 8'h5F;  8'h76: rom_q = 8'h5E;  8'h77: rom_q = 8'h5E;
      8'h78: rom_q = 8'h5D;  8'h79: rom_q = 8'h5C;  8'h7A: rom_q = 8'h5B;  8'h7B: rom_q = 8'h5A;
      8'h7C: rom_q = 8'h59;  8'h7D: rom_q = 8'h58;  8'h7E: rom_q = 8'h57;  8'h7F: rom_q = 8'h56;
      8'h80: rom_q = 8'h55;  8'h81: rom_q = 8'h54;  8'h82: rom_q = 8'h54;  8'h83: rom_q = 8'h53;
      8'h84: rom_q = 8'h52;  8'h85: rom_q = 8'h51;  8'h86: rom_q = 8'h50;  8'h87: rom_q = 8'h4F;
      8'h88: rom_q = 8'h4E;  8'h89: rom_q = 8'h4E;  8'h8A: rom_q = 8'h4D;  8'h8B: rom_q = 8'h4C;
      8'h8C: rom_q = 8'h4B;  8'h8D: rom_q = 8'h4A;  8'h8E: rom_q = 8'h49;  8'h8F: rom_q = 8'h49;
      8'h90: rom_q = 8'h48;  8'h91: rom_q = 8'h47;  8'h92: rom_q = 8'h46;  8'h93: rom_q = 8'h45;
      8'h94: rom_q = 8'h44;  8'h95: rom_q = 8'h44;  8'h96: rom_q = 8'h43;  8'h97: rom_q = 8'h42;
      8'h98: rom_q = 8'h41;  8'h99: rom_q = 8'h40;  8'h9A: rom_q = 8'h40;  8'h9B: rom_q = 8'h3F;
      8'h9C: rom_q = 8'h3E;  8'h9D: rom_q = 8'h3D;  8'h9E: rom_q = 8'h3D;  8'h9F: rom_q = 8'h3C;
      8'hA0: rom_q = 8'h3B;  8'hA1: rom_q = 8'h3A;  8'hA2: rom_q = 8'h3A;  8'hA3: rom_q = 8'h39;
      8'hA4: rom_q = 8'h38;  8'hA5: rom_q = 8'h37;  8'hA6: rom_q = 8'h37;  8'hA7: rom_q = 8'h36;
      8'hA8: rom_q = 8'h35;  8'hA9: rom_q = 8'h34;  8'hAA: rom_q = 8'h34;  8'hAB: rom_q = 8'h33;
      8'hAC: rom_q = 8'h32;  8'hAD: rom_q = 8'h32;  8'hAE: rom_q = 8'h31;  8'hAF: rom_q = 8'h30;
      8'hB0: rom_q = 8'h2F;  8'hB1: rom_q = 8'h2F;  8'hB2: rom_q = 8'h2E;  8'hB3: rom_q = 8'h2D;
      8'hB4: rom_q = 8'h2D;  8'hB5: rom_q = 8'h2C;  8'hB6: rom_q = 8'h2B;  8'hB7: rom_q = 8'h2B;
      8'hB8: rom_q = 8'h2A;  8'hB9: rom_q = 8'h29;  8'hBA: rom_q = 8'h29;  8'hBB: rom_q = 8'h28;
      8'hBC: rom_q = 8'h27;  8'hBD: rom_q = 8'h27;  8'hBE: rom_q = 8'h26;  8'hBF: rom_q = 8'h25;
      8'hC0: rom_q = 8'h25;  8'hC1: rom_q = 8'h24;  8'hC2: rom_q = 8'h23;  8'hC3: rom_q = 8'h23;
      8'hC4: rom_q = 8'h22;  8'hC5: rom_q = 8'h21;  8'hC6: rom_q = 8'h21;  8'hC7: rom_q = 8'h20;
      8'hC8: rom_q = 8'h1F;  8'hC9: rom_q = 8'h1F;  8'hCA: rom_q = 8'h1E;  8'hCB: rom_q = 8'h1E;
      8'hCC: rom_q = 8'h1D;  8'hCD: rom_q = 8'h1C;  8'hCE: rom_q = 8'h1C;  8'hCF: rom_q = 8'h1B;
      8'hD0: rom_q = 8'h1A;  8'hD1: rom_q = 8'h1A;  8'hD2: rom_q = 8'h19;  8'hD3: rom_q = 8'h19;
      8'hD4: rom_q = 8'h18;  8'hD5: rom_q = 8'h17;  8'hD6: rom_q = 8'h17;  8'hD7: rom_q = 8'h16;
      8'hD8: rom_q = 8'h16;  8'hD9: rom_q = 8'h15;  8'hDA: rom_q = 8'h15;  8'hDB: rom_q = 8'h14;
      8'hDC: rom_q = 8'h13;  8'hDD: rom_q = 8'h13;  8'hDE: rom_q = 8'h12;  8'hDF: rom_q = 8'h12;
      8'hE0: rom_q = 8'h11;  8'hE1: rom_q = 8'h10;  8'hE2: rom_q = 8'h10;  8'hE3: rom_q = 8'h0F;
      8'hE4: rom_q = 8'h0F;  8'hE5: rom_q = 8'h0E;  8'hE6: rom_q = 8'h0E;  8'hE7: rom_q = 8'h0D;
      8'hE8: rom_q = 8'h0D;  8'hE9: rom_q = 8'h0C;  8'hEA: rom_q = 8'h0B;  8'hEB: rom_q = 8'h0B;
      8'hEC: rom_q = 8'h0A;  8'hED: rom_q = 8'h0A;  8'hEE: rom_q = 8'h09;  8'hEF: rom_q = 8'h09;
      8'hF0: rom_q = 8'h08;  8'hF1: rom_q = 8'h08;  8'hF2: rom_q = 8'h07;  8'hF3: rom_q = 8'h07;
      8'hF4: rom_q = 8'h06;  8'hF5: rom_q = 8'h06;  8'hF6: rom_q = 8'h05;  8'hF7: rom_q = 8'h05;
      8'hF8: rom_q = 8'h04;  8'hF9: rom_q = 8'h04;  8'hFA: rom_q = 8'h03;  8'hFB: rom_q = 8'h03;
      8'hFC: rom_q = 8'h02;  8'hFD: rom_q = 8'h02;  8'hFE: rom_q = 8'h01;  8'hFF: rom_q = 8'h01;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= 8'h00;
    else       data_q <= rom_q;
  end

  assign rom.data_o = data_q;

endmodule

// File: tb/tb_recip_estimate_rom.sv
// tb/tb_recip_estimate_rom.sv - directed and exhaustive checks of the reciprocal-estimate table
module tb_recip_estimate_rom;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t spot [6];

  recip_estimate_rom_if rif ();

  recip_estimate_rom dut (
    .clk   (clk),
    .reset (reset),
    .rom   (rif)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: data_o=%02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input int a, input logic [7:0] act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: addr=%02h data_o=%02h violates bound", name, a[7:0], act);
    end
  endtask

  function automatic logic [7:0] golden(input int a);
    int d;
    int q;
    d = 256 + a;
    q = (131072 + d / 2) / d;
    return 8'((q - 256) & 255);
  endfunction

  task automatic tick(input logic [7:0] a);
    rif.addr_i = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    real est, inv, err;

    spot[0] = '{8'h00, 8'h00};
    spot[1] = '{8'h01, 8'hFE};
    spot[2] = '{8'h40, 8'h9A};
    spot[3] = '{8'h80, 8'h55};
    spot[4] = '{8'hC0, 8'h25};
    spot[5] = '{8'hFF, 8'h01};

    rif.addr_i = 8'h80;
    reset = 1'b1;
    #1;
    check8("powerup", rif.data_o, 8'h00);

    @(posedge clk); #1;
    check8("reset_c1", rif.data_o, 8'h00);
    @(posedge clk); #1;
    check8("reset_c2", rif.data_o, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    check8("first_after_reset", rif.data_o, 8'h55);

    foreach (spot[i]) begin
      tick(spot[i].addr);
      check8($sformatf("spot_%02h", spot[i].addr), rif.data_o, spot[i].exp);
    end

    // Back-to-back lookups: the output must hold until the edge, then track the new address.
    tick(8'h01);
    check8("lat_01", rif.data_o, 8'hFE);
    rif.addr_i = 8'h40;
    #2;
    check8("lat_hold", rif.data_o, 8'hFE);
    @(posedge clk); #1;
    check8("lat_40", rif.data_o, 8'h9A);
    tick(8'h80);
    check8("lat_80", rif.data_o, 8'h55);

    prev = 8'h00;
    for (int a = 0; a < 256; a++) begin
      tick(8'(a));
      cur = rif.data_o;
      check8($sformatf("sweep_%02h", a), cur, golden(a));
      if (a >= 2)
        check_true("monotonic", cur <= prev, a, cur);
      if (a >= 1) begin
        est = (256.0 + real'(cur)) / 512.0;
        inv = 256.0 / (256.0 + real'(a));
        err = (est > inv) ? est - inv : inv - est;
        check_true("accuracy", err <= inv / 512.0, a, cur);
      end
      prev = cur;
    end

    tick(8'hFF);
    check8("pre_midreset", rif.data_o, 8'h01);
    rif.addr_i = 8'h40;
    reset = 1'b1;
    @(posedge clk); #1;
    check8("midreset_c1", rif.data_o, 8'h00);
    @(posedge clk); #1;
    check8("midreset_c2", rif.data_o, 8'h00);
    rif.addr_i = 8'hC0;
    reset = 1'b0;
    @(posedge clk); #1;
    check8("after_midreset", rif.data_o, 8'h25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/recip_estimate_rom.md
Name: recip_estimate_rom

Overview:
- 256-entry, 8-bit-wide lookup table giving a reciprocal-estimate significand for a floating-point value.
- Indexed by the top 8 fraction bits of an IEEE-754 single significand (implicit leading one excluded).
- Returns the 8 fraction bits of the normalized estimate of 1/m.
- Feeds the seed stage of the FP reciprocal pipeline. That stage adds the leading one and handles the addr=0 overflow case itself.

Parameters:
- None. Address width and data width are both fixed at 8 bits.

Ports:
- clk      input   1  system clock; all state changes on the rising edge
- reset    input   1  synchronous, active-high reset
- addr_i   input   8  table index a = significand[22:15]; represents m = 1 + a/256
- data_o   output  8  registered table entry for the addr_i sampled on the previous rising edge

Behaviour:
- Table function, for a = 0..255:
  - data_o(a) = (round(131072 / (256 + a)) - 256) mod 256.
  - round() is round-to-nearest. Exact halves cannot occur, because 2^18 has no divisor in 257..511.
  - 131072/(256+a) is 2/m scaled by 256, i.e. the normalized estimate 1.xxxxxxxx of 1/m. data_o is its fraction bits.
- addr 0: exact value 512 overflows 8 bits after removing the leading one; the entry is 0x00 (low 8 bits). The consumer detects a zero significand separately.
- Entries are monotonically non-increasing from a=1 to a=255.
  - a=1 gives 254.
  - a=255 gives 1, since 131072/511 = 256.50 rounds to 257.
- The table is constant. Implement it as a 256-way case or an initialized ROM array. No runtime writes.
- Timing:
  - Latency is 1 cycle: addr_i sampled at edge N appears on data_o after edge N.
  - Throughput is one lookup per cycle.
  - Back-to-back address changes each produce their own result one cycle later, with no bubbles.
- Reset:
  - While reset=1 at a rising edge, data_o <= 8'h00, regardless of addr_i.
  - The first valid result appears one edge after reset deasserts, using the addr_i sampled at that edge.
  - Asserting reset mid-stream discards the pending lookup.
- Power-up value of the data_o register is 8'h00.
- No X propagation from the table. Every one of the 256 addresses has a defined entry, with no default/X arm.

Test Plan:
- Reset: hold reset=1 for 2 cycles with addr_i=8'h80 -> data_o=8'h00. Release reset -> next cycle data_o=8'h55.
- Spot values, one per cycle:
  - addr 0x00 -> 0x00
  - addr 0x01 -> 0xFE
  - addr 0x40 -> 0x9A (131072/320 = 409.6 -> 410)
  - addr 0x80 -> 0x55 (341.33 -> 341)
  - addr 0xC0 -> 0x25 (292.57 -> 293)
  - addr 0xFF -> 0x01
- Latency: change addr_i every cycle 0x01,0x40,0x80 -> data_o shows 0xFE,0x9A,0x55 on the following three cycles, each exactly one cycle late.
- Exhaustive sweep: a=0..255, compare each output against the golden model (round(131072/(256+a)) - 256) & 0xFF. Also check entries are non-increasing for a>=1.
- Mid-stream reset: drive addr 0x40, assert reset on the next edge -> data_o=0x00 (0x9A never appears). Deassert with addr 0xC0 held -> 0x25 one cycle later.
- Reciprocal accuracy: for each a>=1, check |(1+data_o/256)/2 - 1/(1+a/256)| <= 2^-9 relative to 1/m. This confirms the seed is within half an LSB.
